// File: rtl/clocked_signal_pkg.sv
// Shared types and constants for the clocked_signal pattern generator.
package clocked_signal_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int unsigned LFSR_W   = 16;
   localparam int unsigned CYC_W    = 5;

   localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 16'hACE1;
   // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
   localparam logic [LFSR_W-1:0] LFSR_TAPS     = 16'hB400;

endpackage

// File: rtl/clocked_signal_if.sv
// Output bundle of clocked_signal: master drives, slave observes.
interface clocked_signal_if
   import clocked_signal_pkg::*;
#(
   parameter int CNT_W = 4
);
   logic [CNT_W-1:0]  cnt;
   logic              cnt_vld;
   logic [1:0]        state;
   logic              done;
   logic [LFSR_W-1:0] lfsr;

   modport master (output cnt, output cnt_vld, output state, output done, output lfsr);
   modport slave  (input  cnt, input  cnt_vld, input  state, input  done, input  lfsr);
endinterface

// File: rtl/clocked_signal_lfsr.sv
// 16-bit Fibonacci LFSR, shifts left by one position on each cycle with adv high.
module clocked_signal_lfsr
   import clocked_signal_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              adv,
   output logic [LFSR_W-1:0] q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= SEED;
      end else if (adv) begin
         q <= {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
      end
   end

endmodule

// File: rtl/clocked_signal.sv
// One-shot IDLE->RUN->HOLD->DONE counter pattern; all outputs registered.
// Define CLOCKED_SIGNAL_LFSR_EN to add the LFSR that steps on every RUN edge.
module clocked_signal
   import clocked_signal_pkg::*;
#(
   parameter int                CNT_W       = 4,
   parameter int                RUN_CYCLES  = 10,
   parameter int                HOLD_CYCLES = 10,
   parameter logic [LFSR_W-1:0] LFSR_SEED   = LFSR_SEED_DEF
) (
   input  logic               clk,
   input  logic               rst,
   clocked_signal_if.master   bus
);

   localparam logic [CYC_W-1:0] RUN_LAST  = CYC_W'(RUN_CYCLES - 1);
   localparam logic [CYC_W-1:0] HOLD_LAST = CYC_W'(HOLD_CYCLES - 1);

   state_t             state_q, state_d;
   logic [CYC_W-1:0]   cyc_q, cyc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               vld_q, vld_d;
   logic               done_q, done_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cyc_q   <= '0;
         cnt_q   <= '0;
         vld_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         cnt_q   <= cnt_d;
         vld_q   <= vld_d;
         done_q  <= done_d;
      end
   end

   // cyc counts edges spent in the current state, entry edge being 0
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q + CYC_W'(1);
      cnt_d   = cnt_q;
      vld_d   = vld_q;
      done_d  = done_q;
      unique case (state_q)
         IDLE: begin
            state_d = RUN;
            cyc_d   = '0;
            cnt_d   = CNT_W'(1);
            vld_d   = 1'b1;
            done_d  = 1'b0;
         end
         RUN: begin
            if (cyc_q == RUN_LAST) begin
               state_d = HOLD;
               cyc_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         HOLD: begin
            if (cyc_q == HOLD_LAST) begin
               state_d = DONE;
               cyc_d   = '0;
               cnt_d   = '0;
               vld_d   = 1'b0;
               done_d  = 1'b1;
            end
         end
         DONE: begin
            cyc_d   = '0;
         end
         default: begin
            state_d = IDLE;
            cyc_d   = '0;
         end
      endcase
   end

   assign bus.cnt     = cnt_q;
   assign bus.cnt_vld = vld_q;
   assign bus.state   = state_q;
   assign bus.done    = done_q;

`ifdef CLOCKED_SIGNAL_LFSR_EN
   logic adv;

   assign adv = (state_d == RUN);

   clocked_signal_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk (clk),
      .rst (rst),
      .adv (adv),
      .q   (bus.lfsr)
   );
`else
   // seed is masked off here; referencing it keeps the parameter live in this build
   assign bus.lfsr = LFSR_SEED & '0;
`endif

endmodule

// File: tb/tb_clocked_signal.sv
// Directed bench for clocked_signal: default DUT plus a RUN_CYCLES=20 instance.
module tb_clocked_signal;
   import clocked_signal_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   clocked_signal_if #(.CNT_W(4)) bus_a ();
   clocked_signal_if #(.CNT_W(4)) bus_b ();

   clocked_signal #(.CNT_W(4), .RUN_CYCLES(10), .HOLD_CYCLES(10), .LFSR_SEED(16'hACE1)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   clocked_signal #(.CNT_W(4), .RUN_CYCLES(20), .HOLD_CYCLES(10), .LFSR_SEED(16'hACE1)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   typedef struct {
      logic        rst;
      int          k;
      logic [1:0]  a_state;
      logic [3:0]  a_cnt;
      logic        a_vld;
      logic        a_done;
      logic [15:0] a_lfsr;
      logic [1:0]  b_state;
      logic [3:0]  b_cnt;
      logic [15:0] b_lfsr;
   } vec_t;

   vec_t vecs[45];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Expected LFSR word after n advances from the default seed
   function automatic logic [15:0] lfsr_exp(input int n);
      logic [15:0] v;
`ifdef CLOCKED_SIGNAL_LFSR_EN
      v = 16'hACE1;
      for (int i = 0; i < n; i++) v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
`else
      v = 16'h0000;
      if (n < 0) v = 16'hFFFF;
`endif
      return v;
   endfunction

   task automatic chk_outputs(input string tag, input vec_t v);
      chk($sformatf("%s a_state", tag), 32'(bus_a.state),   32'(v.a_state));
      chk($sformatf("%s a_cnt",   tag), 32'(bus_a.cnt),     32'(v.a_cnt));
      chk($sformatf("%s a_vld",   tag), 32'(bus_a.cnt_vld), 32'(v.a_vld));
      chk($sformatf("%s a_done",  tag), 32'(bus_a.done),    32'(v.a_done));
      chk($sformatf("%s a_lfsr",  tag), 32'(bus_a.lfsr),    32'(v.a_lfsr));
      chk($sformatf("%s b_state", tag), 32'(bus_b.state),   32'(v.b_state));
      chk($sformatf("%s b_cnt",   tag), 32'(bus_b.cnt),     32'(v.b_cnt));
      chk($sformatf("%s b_lfsr",  tag), 32'(bus_b.lfsr),    32'(v.b_lfsr));
   endtask

   initial begin
      vec_t v;

      // 5 reset edges, then 40 edges after release
      for (int i = 0; i < 45; i++) begin
         v.rst = (i >= 5);
         v.k   = (i >= 5) ? i - 4 : 0;
         if (v.k == 0) begin
            v.a_state = 2'd0; v.a_cnt = 4'd0; v.a_vld = 1'b0; v.a_done = 1'b0;
            v.b_state = 2'd0; v.b_cnt = 4'd0;
         end else begin
            if (v.k <= 10) begin
               v.a_state = 2'd1; v.a_cnt = 4'(v.k); v.a_vld = 1'b1; v.a_done = 1'b0;
            end else if (v.k <= 20) begin
               v.a_state = 2'd2; v.a_cnt = 4'd10; v.a_vld = 1'b1; v.a_done = 1'b0;
            end else begin
               v.a_state = 2'd3; v.a_cnt = 4'd0;  v.a_vld = 1'b0; v.a_done = 1'b1;
            end
            if (v.k <= 20) begin
               v.b_state = 2'd1; v.b_cnt = 4'(v.k % 16);
            end else if (v.k <= 30) begin
               v.b_state = 2'd2; v.b_cnt = 4'd4;
            end else begin
               v.b_state = 2'd3; v.b_cnt = 4'd0;
            end
         end
         v.a_lfsr = lfsr_exp((v.k < 10) ? v.k : 10);
         v.b_lfsr = lfsr_exp((v.k < 20) ? v.k : 20);
         vecs[i] = v;
      end

      for (int i = 0; i < 45; i++) begin
         @(negedge clk);
         rst = vecs[i].rst;
         @(posedge clk);
         #1;
         chk_outputs($sformatf("edge%0d", vecs[i].k), vecs[i]);
      end

`ifdef CLOCKED_SIGNAL_LFSR_EN
      chk("lfsr_step1_const", 32'(lfsr_exp(1)), 32'h59C3);
`endif

      // Async reset out of DONE, without a clock edge
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("done_async_rst state", 32'(bus_a.state), 32'd0);
      chk("done_async_rst done",  32'(bus_a.done),  32'd0);

      // Release, run to cnt=6, then assert reset mid-cycle
      @(negedge clk);
      rst = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("midrun cnt6", 32'(bus_a.cnt), 32'd6);
      #2;
      rst = 1'b0;
      #1;
      chk("midrun_rst state", 32'(bus_a.state),   32'd0);
      chk("midrun_rst cnt",   32'(bus_a.cnt),     32'd0);
      chk("midrun_rst vld",   32'(bus_a.cnt_vld), 32'd0);
      chk("midrun_rst done",  32'(bus_a.done),    32'd0);
      chk("midrun_rst lfsr",  32'(bus_a.lfsr),    32'(lfsr_exp(0)));
      @(posedge clk);
      #1;
      chk("held_rst state", 32'(bus_a.state), 32'd0);

      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("restart1 state", 32'(bus_a.state), 32'd1);
      chk("restart1 cnt",   32'(bus_a.cnt),   32'd1);
      chk("restart1 lfsr",  32'(bus_a.lfsr),  32'(lfsr_exp(1)));
      @(posedge clk);
      #1;
      chk("restart2 cnt",   32'(bus_a.cnt),   32'd2);
      chk("restart2 lfsr",  32'(bus_a.lfsr),  32'(lfsr_exp(2)));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/clocked_signal.md
CLOCKED_SIGNAL -- requirements
Module: clocked_signal

Interface
REQ-001 SHALL have a single clock and an asynchronous active-low reset, with ports named clk and rst.
REQ-002 Parameter: CNT_W, 4, width of the count output.
REQ-003 Parameter: RUN_CYCLES, 10, number of incrementing cycles, range 1..31.
REQ-004 Parameter: HOLD_CYCLES, 10, number of hold cycles after RUN, range 1..31.
REQ-005 Parameter: LFSR_SEED, 16'hACE1, LFSR value loaded at reset; must be nonzero.
REQ-006 Port: clk  input  1  rising-edge clock.
REQ-007 Port: rst  input  1  asynchronous reset, active low.
REQ-008 Port: cnt  output  CNT_W  pattern counter.
REQ-009 Port: cnt_vld  output  1  high while cnt carries a valid value.
REQ-010 Port: state  output  2  current FSM state: IDLE=0, RUN=1, HOLD=2, DONE=3.
REQ-011 Port: done  output  1  level, high in DONE.
REQ-012 Port: lfsr  output  16  pseudo-random word.

Function
REQ-013 SHALL implement FSM IDLE->RUN->HOLD->DONE; DONE is terminal until reset is asserted.
REQ-014 IDLE: the first rising clk edge with rst high SHALL enter RUN, set cnt=1 and cnt_vld=1.
REQ-015 RUN: each edge SHALL increment cnt by 1 modulo 2^CNT_W, so edge k after release gives cnt=k.
REQ-016 After RUN_CYCLES edges in RUN, including the entry edge, the next edge SHALL enter HOLD with cnt unchanged.
REQ-017 HOLD: cnt SHALL stay frozen and cnt_vld SHALL stay 1 for HOLD_CYCLES edges, counting the entry edge.
REQ-018 At the end of HOLD the next edge SHALL enter DONE with cnt=0, cnt_vld=0 and done=1.
REQ-019 An internal 5-bit cycle counter SHALL clear on every state change and SHALL NOT be an output.
REQ-020 All outputs SHALL be registered; state SHALL be a direct register copy, with no combinational paths from rst or clk.
REQ-021 Reset asserted in any state SHALL immediately force IDLE values (REQ-023), with no residual cycle count.
REQ-022 With defaults: cnt is 1..10 over 10 edges, holds 10 for 10 edges, then goes to 0 with cnt_vld=0 at edge 21 after release.

Reset
REQ-023 While rst=0: state=IDLE, cnt=0, cnt_vld=0, done=0, lfsr=LFSR_SEED, cycle counter=0.
REQ-024 Reset assertion SHALL be asynchronous; release SHALL take effect on the first rising clk edge with rst=1.

Configuration
REQ-025 Macro CLOCKED_SIGNAL_LFSR_EN defined: lfsr SHALL be a 16-bit Fibonacci LFSR, taps 16,14,13,11.
REQ-026 With the macro, the LFSR SHALL shift left, new LSB = b15^b13^b12^b10, advancing once per RUN edge, including the RUN entry edge.
REQ-027 With the macro, the LFSR SHALL hold its value in IDLE, HOLD and DONE.
REQ-028 Macro undefined: lfsr SHALL be constant 0 and no LFSR flops SHALL be synthesized.

Structure
REQ-029 Package clocked_signal_pkg SHALL hold the state enum (2-bit), the default LFSR seed and the tap mask.
REQ-030 The LFSR SHALL be a sub-module clocked_signal_lfsr (clk, rst, adv, q), instantiated only under CLOCKED_SIGNAL_LFSR_EN.

Verification
REQ-031 Hold rst=0 for 5 edges, then release -> edges 1..10: cnt=1..10, cnt_vld=1, state=RUN; edges 11..20: cnt=10, state=HOLD.
REQ-032 Default run to completion -> edge 21: state=DONE, done=1, cnt=0, cnt_vld=0; no change through edge 40.
REQ-033 Assert rst mid-RUN at cnt=6 -> outputs go to reset values without a clock edge; after release the count restarts at 1.
REQ-034 CNT_W=4, RUN_CYCLES=20 -> cnt goes 15 then 0 at edges 15 and 16; HOLD holds cnt=4.
REQ-035 Macro on, defaults -> after edge 1 lfsr=16'h59C3; lfsr frozen in HOLD at its 10th-step value; macro off -> lfsr=0 always.
